prog_loader: RTL
================

Name: prog_loader

Overview:
- Boot-time program loader that sits directly upstream of the 3-bit-PC CPU and its 8 x 9-bit instruction/data memory.
- Accepts a stream of 9-bit words over a valid/ready handshake and writes them to memory addresses 0..DEPTH-1.
- Holds the CPU in reset while loading, then releases it so execution starts at PC=0 with memory fully populated.

Parameters:
WORD_W, 9, memory word width
ADDR_W, 3, memory address width
DEPTH, 8, words per load; must equal 2**ADDR_W

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  begin (re)load; one-cycle pulse, sampled in IDLE, RUN, ERROR only
in_valid  input  1  in_data is valid
in_data  input  WORD_W  program word
in_ready  output  1  loader can accept a word (registered)
mem_we  output  1  memory write strobe, one cycle per accepted word
mem_addr  output  ADDR_W  memory write address
mem_wdata  output  WORD_W  memory write data
cpu_reset  output  1  active-high reset to the CPU
done  output  1  load complete, CPU running
word_count  output  ADDR_W+1  words accepted this load, 0..DEPTH
err  output  1  checksum mismatch; tied 0 without the optional feature

Behaviour:
- Reset low, asynchronous: state IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_reset=1, done=0, word_count=0, err=0. Memory contents are not cleared.
- All outputs are registered.
- States: IDLE, LOAD, RELEASE, RUN, plus CHECK and ERROR when the optional feature is compiled in.
- IDLE: in_ready=0. start=1 -> LOAD with word_count=0 and in_ready=1 from the next cycle.
- LOAD:
  - Transfer occurs on each edge where in_valid&in_ready=1; at most one word per cycle.
  - The cycle after a transfer: mem_we=1, mem_addr=word_count (pre-increment value), mem_wdata=in_data. Write latency is exactly 1 cycle.
  - word_count increments on each transfer.
  - in_valid=0 cycles: no write, no count change.
  - in_valid without in_ready: word is not consumed.
- DEPTH-th transfer: in_ready=0 at the same edge, then go to RELEASE (or CHECK if the optional feature is compiled in).
- RELEASE: one cycle. The final mem_we happens here and cpu_reset stays 1.
- Next edge -> RUN: cpu_reset=0, done=1. The CPU's first fetch therefore sees all DEPTH words written.
- RUN: holds until start=1. Then, at the next edge: cpu_reset=1, done=0, word_count=0, in_ready=1, state LOAD.
- start in LOAD, RELEASE, or CHECK: ignored.
- word_count saturates at DEPTH. mem_addr never wraps within a load.
- Reset asserted mid-load: immediate return to reset values. Memory is partially written. The next start reloads from address 0.

Optional Feature:
Macro: LOADER_CHECKSUM_EN
- Defined:
  - After the DEPTH-th word, enter CHECK with in_ready=1; accept exactly one extra checksum word with no memory write.
  - Expected checksum = sum of the DEPTH words mod 2**WORD_W.
  - Match -> RELEASE.
  - Mismatch -> ERROR: in_ready=0, err=1, cpu_reset=1, done=0. ERROR holds until start, which clears err and goes to LOAD, or until reset.
- Undefined: CHECK and ERROR do not exist, err is constant 0, and the DEPTH-th word goes directly to RELEASE.

Test Plan:
1. Hold reset=0 for 2 cycles -> in_ready=0, mem_we=0, cpu_reset=1, done=0, word_count=0, err=0.
2. Pulse start, then stream 0x12A,0x1B8,0x1BA,0x000,0x001,0x005,0x000,0x1CF back-to-back -> 8 mem_we pulses at addr 0..7 with matching data. cpu_reset falls and done rises 2 edges after the last accept. The CPU PC then counts from 0.
3. Same words with in_valid low every other cycle -> writes occur only after handshakes, addresses stay contiguous, word_count=8 at the end, no extra writes.
4. Reset low after 3 accepts -> all outputs at reset values immediately. Pulse start and load 8 words -> first write at addr 0.
5. Pulse start in RUN -> cpu_reset=1 and done=0 next edge. A full reload of 8 words releases the CPU again.
6. With LOADER_CHECKSUM_EN: the case-2 words plus checksum 0x071 -> RUN. Checksum 0x070 instead -> err=1, cpu_reset stays 1. A following start clears err and restarts the load.

Source files
------------

// File: rtl/prog_loader.sv
// prog_loader: boot-time program loader for the 3-bit-PC CPU.
// Streams DEPTH words over a valid/ready handshake into the instruction/data
// memory at addresses 0..DEPTH-1, holding the CPU in reset until the last
// write has landed, then releases it so the first fetch sees a full memory.
// Optional feature: define LOADER_CHECKSUM_EN to require one extra checksum
// word (sum of the DEPTH words mod 2**WORD_W) before the CPU is released.
// DEPTH must equal 2**ADDR_W.
module prog_loader #(
    parameter int WORD_W = 9,
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              cpu_reset,
    output logic              done,
    output logic [ADDR_W:0]   word_count,
    output logic              err
);

    localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RELEASE,
`ifdef LOADER_CHECKSUM_EN
        RUN,
        CHECK,
        ERROR
`else
        RUN
`endif
    } state_t;

    state_t state;

    logic transfer;
    assign transfer = in_valid && in_ready;

`ifdef LOADER_CHECKSUM_EN
    logic [WORD_W-1:0] sum;
    logic              err_q;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // Loader FSM; every output is a register updated here.
    // NOTE: all state uses non-blocking assignments so every register samples
    // the pre-edge values of the others, exactly like the flops they become.
    // NOTE: the program memory lives downstream and is deliberately not
    // cleared on reset; a reset mid-load leaves it partially written.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            in_ready   <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cpu_reset  <= 1'b1;
            done       <= 1'b0;
            word_count <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum        <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            // The write strobe is a single-cycle pulse unless a transfer renews it.
            mem_we <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= LOAD;
                        word_count <= '0;
                        in_ready   <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
                        sum        <= '0;
`endif
                    end
                end

                LOAD: begin
                    if (transfer) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= word_count[ADDR_W-1:0];
                        mem_wdata <= in_data;
                        if (word_count != CNT_FULL) begin
                            word_count <= word_count + CNT_ONE;
                        end
`ifdef LOADER_CHECKSUM_EN
                        sum <= sum + in_data;
`endif
                        if (word_count == CNT_LAST) begin
`ifdef LOADER_CHECKSUM_EN
                            // Keep in_ready high for the checksum word.
                            state <= CHECK;
`else
                            in_ready <= 1'b0;
                            state    <= RELEASE;
`endif
                        end
                    end
                end

                // The last write lands during this cycle; the CPU stays in reset.
                RELEASE: begin
                    state     <= RUN;
                    cpu_reset <= 1'b0;
                    done      <= 1'b1;
                end

                RUN: begin
                    if (start) begin
                        state      <= LOAD;
                        cpu_reset  <= 1'b1;
                        done       <= 1'b0;
                        word_count <= '0;
                        in_ready   <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
                        sum        <= '0;
`endif
                    end
                end

`ifdef LOADER_CHECKSUM_EN
                // One checksum word, compared against the running sum, never written.
                CHECK: begin
                    if (transfer) begin
                        in_ready <= 1'b0;
                        if (in_data == sum) begin
                            state <= RELEASE;
                        end else begin
                            state <= ERROR;
                            err_q <= 1'b1;
                        end
                    end
                end

                // Bad image: CPU held in reset until software asks for a reload.
                ERROR: begin
                    if (start) begin
                        state      <= LOAD;
                        err_q      <= 1'b0;
                        word_count <= '0;
                        in_ready   <= 1'b1;
                        sum        <= '0;
                    end
                end
`endif

                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
